// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
//   - Segment bit positions inside the 7-bit {g,f,e,d,c,b,a} pattern word.
//   - Active-high patterns for digits 0..9 and a dash shown for non-BCD nibbles.
//   - NUM_DIGITS: number of multiplexed digits on the display.
//   - phase_t: where the scanner is within a digit slot (exposed for debug).
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D)
                                    | (1 << SEG_E) | (1 << SEG_F));
    localparam logic [6:0] SEG_1 = 7'((1 << SEG_B) | (1 << SEG_C));
    localparam logic [6:0] SEG_2 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_D) | (1 << SEG_E)
                                    | (1 << SEG_G));
    localparam logic [6:0] SEG_3 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D)
                                    | (1 << SEG_G));
    localparam logic [6:0] SEG_4 = 7'((1 << SEG_B) | (1 << SEG_C) | (1 << SEG_F) | (1 << SEG_G));
    localparam logic [6:0] SEG_5 = 7'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_F)
                                    | (1 << SEG_G));
    localparam logic [6:0] SEG_6 = 7'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E)
                                    | (1 << SEG_F) | (1 << SEG_G));
    localparam logic [6:0] SEG_7 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C));
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D)
                                    | (1 << SEG_F) | (1 << SEG_G));
    localparam logic [6:0] SEG_DASH = 7'(1 << SEG_G);

    typedef enum logic [1:0] {
        PH_OFF  = 2'd0,  // scanning disabled
        PH_DEAD = 2'd1,  // start of slot, all digits off
        PH_ON   = 2'd2   // selected digit driven
    } phase_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value-update channel of the seven-segment scan driver.
//   value_i        16  four BCD digits, [3:0] is digit 0
//   value_valid_i   1  source offers value_i
//   value_ready_o   1  driver can take a value
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds value_i stable while valid is high; ready
// may be low for many cycles and valid is simply ignored while it is.
interface seg7_scan_driver_if;
    logic [15:0] value_i;
    logic        value_valid_i;
    logic        value_ready_o;

    modport master (output value_i, output value_valid_i, input value_ready_o);
    modport slave  (input value_i, input value_valid_i, output value_ready_o);
endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to seven-segment pattern decoder.
//   nibble  in   4  digit value
//   seg     out  7  {g,f,e,d,c,b,a}, active high; A..F show a dash
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-cathode seven-segment display.
// A new value is taken through a valid/ready channel into a pending buffer and
// only copied to the display register at a frame boundary (or at once while
// scanning is disabled). Each digit slot lasts CLK_DIV cycles, the first
// DEAD_CYCLES of which keep every digit off to avoid ghosting.
//   wb_clk_i     in   1  clock
//   wb_rst_n     in   1  asynchronous active-low reset
//   enable_i     in   1  scan enable; low blanks the display
//   blank_lz_i   in   1  leading-zero suppression
//   value_if     slave   value channel (value_i / value_valid_i / value_ready_o)
//   seven_seg    out  7  registered segment pattern {g,f,e,d,c,b,a}
//   digit_en     out  4  registered one-hot digit select
//   frame_o      out  1  pulse in the last cycle of the digit-3 slot
//   dbg_phase    out  2  current slot phase, for observation only
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 2500,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n,
    input  logic                  enable_i,
    input  logic                  blank_lz_i,
    seg7_scan_driver_if.slave     value_if,
    output logic [6:0]            seven_seg,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_o,
    output phase_t                dbg_phase
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DEAD_LEN  = PW'(DEAD_CYCLES);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [15:0]             display_q;
    logic [15:0]             pending_q;
    logic                    pending_full_q;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   en_d;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;
    logic                    boundary;
    logic                    accept;
    logic                    xfer;
    phase_t                  phase;

    assign nibble = display_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // A digit is suppressed when it and every digit above it are zero; the
    // chain starts at digit 3 and digit 0 always shows.
    always_comb begin
        blank    = '0;
        blank[3] = blank_lz_i && (display_q[15:12] == 4'd0);
        blank[2] = blank[3] && (display_q[11:8] == 4'd0);
        blank[1] = blank[2] && (display_q[7:4] == 4'd0);
    end

    assign boundary = enable_i && (pcnt_q == PCNT_LAST) && (idx_q == 2'd3);
    assign accept   = value_if.value_valid_i && !pending_full_q;
    // While disabled every cycle acts as a boundary so updates still land.
    assign xfer     = pending_full_q && (boundary || !enable_i);

    assign value_if.value_ready_o = !pending_full_q;
    assign frame_o   = boundary;
    assign dbg_phase = phase;

    // Next scan position and the output pattern for the current position;
    // the pattern is registered, so outputs lag pcnt/idx by one cycle.
    always_comb begin
        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        phase  = PH_OFF;
        seg_d  = '0;
        en_d   = '0;
        if (!enable_i) begin
            pcnt_d = '0;
            idx_d  = '0;
        end else begin
            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                idx_d  = 2'(idx_q + 2'd1);
            end else begin
                pcnt_d = PW'(pcnt_q + 1'b1);
            end
            if (pcnt_q < DEAD_LEN) begin
                phase = PH_DEAD;
            end else begin
                phase = PH_ON;
                en_d  = NUM_DIGITS'(1) << idx_q;
                seg_d = blank[idx_q] ? 7'd0 : dec_seg;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            pcnt_q         <= '0;
            idx_q          <= '0;
            seven_seg      <= '0;
            digit_en       <= '0;
            display_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            seven_seg <= seg_d;
            digit_en  <= en_d;
            if (accept) begin
                pending_q      <= value_if.value_i;
                pending_full_q <= 1'b1;
            end else if (xfer) begin
                display_q      <= pending_q;
                pending_full_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       blank_lz;
    logic [6:0] seven_seg;
    logic [3:0] digit_en;
    logic       frame_o;
    phase_t     dbg_phase;

    int tests_run;
    int tests_failed;

    // expected segment patterns, four per frame, digit 0 first
    logic [6:0] exp_q[$];

    seg7_scan_driver_if vif ();

    seg7_scan_driver #(
        .CLK_DIV     (8),
        .DEAD_CYCLES (2)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .enable_i   (enable),
        .blank_lz_i (blank_lz),
        .value_if   (vif.slave),
        .seven_seg  (seven_seg),
        .digit_en   (digit_en),
        .frame_o    (frame_o),
        .dbg_phase  (dbg_phase)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        exp_q.push_back(s0);
        exp_q.push_back(s1);
        exp_q.push_back(s2);
        exp_q.push_back(s3);
    endtask

    // Steps until frame_o is seen at a negedge, bounded.
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        step();
        while (frame_o !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check({tag, " frame_seen"}, 32'(frame_o), 32'd1);
    endtask

    // Entered at a negedge where the scanner sits at pcnt 0 / idx 0; checks one
    // whole frame and returns at the same point of the next frame. Optionally
    // offers a value when digit offer_d starts, then a second value while busy.
    task automatic check_frame(input string tag, input int offer_d, input logic [15:0] offer_v);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_en;
        logic [6:0] exp_sg;
        check({tag, " exp_q"}, 32'(exp_q.size() >= 4), 32'd1);
        for (int d = 0; d < 4; d++)
            exp_seg[d] = (exp_q.size() > 0) ? exp_q.pop_front() : 7'd0;
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < 8; j++) begin
                step();
                exp_en = (j < 2) ? 4'd0 : 4'(1 << d);
                exp_sg = (j < 2) ? 7'd0 : exp_seg[d];
                check($sformatf("%s d%0d c%0d digit_en", tag, d, j), 32'(digit_en), 32'(exp_en));
                check($sformatf("%s d%0d c%0d seven_seg", tag, d, j), 32'(seven_seg), 32'(exp_sg));
                check($sformatf("%s d%0d c%0d frame_o", tag, d, j), 32'(frame_o),
                      32'(d == 3 && j == 6));
                if (d == offer_d) begin
                    if (j == 0) begin
                        vif.value_valid_i = 1'b1;
                        vif.value_i       = offer_v;
                    end
                    if (j == 1) begin
                        check({tag, " ready_low"}, 32'(vif.value_ready_o), 32'd0);
                        vif.value_i = 16'h9999;
                    end
                    if (j == 3) vif.value_valid_i = 1'b0;
                end
            end
        end
    endtask

    // Offers a value at ready, then lands at the start of the frame showing it.
    task automatic load_value(input string tag, input logic [15:0] v);
        vif.value_valid_i = 1'b1;
        vif.value_i       = v;
        step();
        vif.value_valid_i = 1'b0;
        check({tag, " ready_low"}, 32'(vif.value_ready_o), 32'd0);
        wait_frame(tag);
        step();
        check({tag, " ready_high"}, 32'(vif.value_ready_o), 32'd1);
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst_n             = 1'b0;
        enable            = 1'b0;
        blank_lz          = 1'b0;
        vif.value_valid_i = 1'b0;
        vif.value_i       = 16'h0000;

        // reset state
        repeat (3) step();
        check("rst seven_seg", 32'(seven_seg), 32'd0);
        check("rst digit_en", 32'(digit_en), 32'd0);
        check("rst frame_o", 32'(frame_o), 32'd0);
        check("rst ready", 32'(vif.value_ready_o), 32'd1);

        // first value, shown from the frame after the first boundary
        rst_n             = 1'b1;
        enable            = 1'b1;
        vif.value_valid_i = 1'b1;
        vif.value_i       = 16'h1234;
        step();
        vif.value_valid_i = 1'b0;
        check("s1 ready_low", 32'(vif.value_ready_o), 32'd0);
        wait_frame("s1");
        check("s1 ready_at_frame", 32'(vif.value_ready_o), 32'd0);
        step();
        check("s1 ready_after_frame", 32'(vif.value_ready_o), 32'd1);
        push4(7'h66, 7'h4F, 7'h5B, 7'h06);
        check_frame("f1234a", -1, 16'h0);

        // update mid-frame: 1234 stays until the boundary, 9999 is never taken
        push4(7'h66, 7'h4F, 7'h5B, 7'h06);
        check_frame("f1234b", 1, 16'h5678);
        check("s2 ready_high", 32'(vif.value_ready_o), 32'd1);
        push4(7'h7F, 7'h07, 7'h7D, 7'h6D);
        check_frame("f5678a", -1, 16'h0);
        push4(7'h7F, 7'h07, 7'h7D, 7'h6D);
        check_frame("f5678b", -1, 16'h0);

        // leading-zero blanking
        blank_lz = 1'b1;
        load_value("s3a", 16'h0070);
        push4(7'h3F, 7'h07, 7'h00, 7'h00);
        check_frame("f0070lz", -1, 16'h0);
        load_value("s3b", 16'h0000);
        push4(7'h3F, 7'h00, 7'h00, 7'h00);
        check_frame("f0000lz", -1, 16'h0);

        // non-BCD nibble shows a dash and counts as nonzero
        blank_lz = 1'b0;
        load_value("s4", 16'h00A0);
        push4(7'h3F, 7'h40, 7'h3F, 7'h3F);
        check_frame("f00A0", -1, 16'h0);
        blank_lz = 1'b1;
        push4(7'h3F, 7'h40, 7'h00, 7'h00);
        check_frame("f00A0lz", -1, 16'h0);

        // disable mid-slot with a value offered while disabled
        repeat (4) step();
        check("s5 on_en", 32'(digit_en), 32'd1);
        check("s5 on_seg", 32'(seven_seg), 32'h3F);
        enable            = 1'b0;
        vif.value_valid_i = 1'b1;
        vif.value_i       = 16'h0321;
        step();
        vif.value_valid_i = 1'b0;
        check("s5 off_en", 32'(digit_en), 32'd0);
        check("s5 off_seg", 32'(seven_seg), 32'd0);
        check("s5 off_frame", 32'(frame_o), 32'd0);
        check("s5 off_ready_low", 32'(vif.value_ready_o), 32'd0);
        step();
        check("s5 off_ready_high", 32'(vif.value_ready_o), 32'd1);
        repeat (3) step();
        check("s5 idle_en", 32'(digit_en), 32'd0);
        check("s5 idle_seg", 32'(seven_seg), 32'd0);
        check("s5 idle_frame", 32'(frame_o), 32'd0);
        enable = 1'b1;
        push4(7'h06, 7'h5B, 7'h4F, 7'h00);
        check_frame("f0321lz", -1, 16'h0);

        // async reset mid-ON with a pending value
        vif.value_valid_i = 1'b1;
        vif.value_i       = 16'h0888;
        step();
        vif.value_valid_i = 1'b0;
        check("s6 ready_low", 32'(vif.value_ready_o), 32'd0);
        repeat (3) step();
        check("s6 on_en", 32'(digit_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s6 rst_seg", 32'(seven_seg), 32'd0);
        check("s6 rst_en", 32'(digit_en), 32'd0);
        check("s6 rst_frame", 32'(frame_o), 32'd0);
        check("s6 rst_ready", 32'(vif.value_ready_o), 32'd1);
        step();
        rst_n = 1'b1;
        push4(7'h3F, 7'h00, 7'h00, 7'h00);
        check_frame("frst_a", -1, 16'h0);
        push4(7'h3F, 7'h00, 7'h00, 7'h00);
        check_frame("frst_b", -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the 4-digit common-cathode seven-segment display on the user IO pads. It takes a 4-digit BCD value through a valid/ready handshake and double-buffers it, so updates apply only at frame boundaries. It scans one digit at a time with a programmable slot length and anti-ghosting dead time. Its seven_seg and digit_en outputs feed the IO assignment {seven_seg, digit_en} in the user project wrapper.

Parameters:
CLK_DIV, 2500, wb_clk_i cycles per digit slot; legal range 2..65535.
DEAD_CYCLES, 16, cycles at the start of each slot with all digits off; must satisfy 0 <= DEAD_CYCLES < CLK_DIV.

Ports:
wb_clk_i  input  1  system clock.
wb_rst_n  input  1  asynchronous active-low reset.
enable_i  input  1  scan enable; low blanks the display.
value_i  input  16  BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
value_valid_i  input  1  value_i offered.
value_ready_o  output  1  pending buffer empty; value is accepted when valid and ready are both high.
blank_lz_i  input  1  leading-zero suppression enable.
seven_seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
digit_en  output  4  one-hot digit select, active-high; bit n selects digit n; registered.
frame_o  output  1  one-cycle pulse at each frame boundary (digit 3 slot ends).

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - seven_seg = 0, digit_en = 0, frame_o = 0, value_ready_o = 1.
  - Prescaler = 0, digit index = 0, display register = 0, pending register empty.
- State:
  - Prescaler pcnt counts 0..CLK_DIV-1 and wraps.
  - Digit index idx is 2 bits and advances when pcnt == CLK_DIV-1 (0→1→2→3→0).
- Phases within a slot:
  - pcnt < DEAD_CYCLES is the DEAD phase; otherwise the ON phase.
  - One-cycle output register: the outputs reflect the pcnt/idx of the previous cycle.
  - DEAD: digit_en = 0, seven_seg = 0.
  - ON: digit_en = 1<<idx; seven_seg = decode(display digit idx), or 0 if that digit is blanked.
- Handshake:
  - Accept when value_valid_i && value_ready_o; the accepted value goes into pending and pending becomes full.
  - value_ready_o = !pending_full.
  - value_valid_i is ignored while ready is low, and the offered data is not captured.
- Frame boundary: the cycle where idx == 3 and pcnt == CLK_DIV-1.
  - If pending is full, pending moves to the display register and is emptied; ready rises the next cycle.
  - frame_o pulses in the same cycle.
  - Accepting a new value in the boundary cycle is impossible, because ready is low whenever pending is full.
- Decode:
  - 0–9 use the standard segment patterns.
  - Nibbles A–F display a dash (g only, 7'b1000000).
- Leading-zero blank (only when blank_lz_i = 1, evaluated combinationally on the display register):
  - Digit n, for n = 3..1, is blanked if it and every higher digit equal 0.
  - Digit 0 is never blanked.
  - Non-BCD nibbles count as nonzero.
- enable_i low:
  - pcnt and idx are held at 0, next outputs are 0, and frame_o = 0.
  - Every cycle is treated as a frame boundary for the pending→display transfer, so updates are not lost while disabled.
- enable_i rising: scanning restarts at idx 0, pcnt 0, with a DEAD phase first.
- Width rule: pcnt width = $clog2(CLK_DIV); comparisons are unsigned.
- Reset mid-scan: everything returns to reset values immediately, including the outputs; an accepted but undisplayed pending value is discarded.

Decomposition:
- Package seg7_pkg holds:
  - the segment pattern constants SEG_0..SEG_9 and SEG_DASH;
  - the digit count constant NUM_DIGITS = 4;
  - the segment bit-order localparams.
- Sub-module seg7_decode is purely combinational: 4-bit nibble → 7-bit pattern. Instantiate it once, fed by a mux on idx.
- The scan FSM, handshake and blanking logic stay in the top.

Test Plan:
All scenarios use CLK_DIV=8, DEAD_CYCLES=2.
- Reset then enable, value 0x1234 accepted:
  - ready drops and rises after the first frame_o.
  - The next frame shows digit_en 0001/0010/0100/1000 with seven_seg 0x66 ('4'), 0x4F, 0x5B, 0x06.
  - Each digit is on for 6 cycles after 2 dead cycles.
- Update during a frame: offer 0x5678 at idx = 1:
  - The display keeps 0x1234 until frame_o, then shows 0x5678.
  - A second valid offered while ready = 0 is ignored.
- Leading-zero blanking: value 0x0070 with blank_lz_i = 1:
  - Digits 3 and 2 show seven_seg 0 while their digit_en bit is still active.
  - Digit 1 shows 0x07 and digit 0 shows 0x3F.
  - Value 0x0000 shows only digit 0 = 0x3F.
- Non-BCD value: 0x00A0 → digit 1 shows 0x40. With blank_lz_i = 1, digits 3 and 2 are blanked.
- enable_i low mid-slot:
  - Outputs are 0 from the next cycle.
  - A value offered while disabled moves to display at once, and ready is back to 1 the following cycle.
  - On re-enable, 2 dead cycles precede digit 0.
- Async wb_rst_n pulse mid-ON-phase with pending full:
  - All outputs go to 0 without waiting for a clock edge, and ready = 1.
  - After release, the display shows 0000 (digit 0 = 0x3F when blank_lz_i = 1).
